// File: rtl/mainfsm_pkg.sv
// Shared controller package: state encodings plus the ALU B and result mux codes.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/flopr.sv
// Generic resettable register: clears to zero on a synchronous active-high reset.
module flopr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle controller main FSM (Moore): sequences fetch, decode, memory,
// ALU and branch steps; outputs depend on the state register alone.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);
  import mainfsm_pkg::*;

  logic [3:0] state_d;
  logic [3:0] state_q;
  logic       unused_funct;

  // Only the I and L bits steer the sequence.
  assign unused_funct = ^Funct[4:1];

  flopr #(.WIDTH(4)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (state_d),
    .q     (state_q)
  );

  // Next-state logic; Op/Funct are consulted only in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00: begin
            if (Funct[5]) begin
              state_d = S_EXECUTEI;
            end else begin
              state_d = S_EXECUTER;
            end
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        if (Funct[0]) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; UNKNOWN and encodings 11-15 leave every output low.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      // Data-processing write-back lands here so delayed FlagWrite aligns.
      S_ALUWB: RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
      end
      default: begin
        IRWrite = 1'b0;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: walks every instruction class and checks state
// plus the full output word each cycle against a hand-written table.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic       irwrite, adrsrc, alusrca, aluop, nextpc, regw, memw, branch;
  logic [1:0] alusrcb, resultsrc;
  logic [3:0] state;
  logic [11:0] obs_word;
  int checks = 0;
  int errors = 0;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (op),
    .Funct     (funct),
    .IRWrite   (irwrite),
    .AdrSrc    (adrsrc),
    .ALUSrcA   (alusrca),
    .ALUSrcB   (alusrcb),
    .ResultSrc (resultsrc),
    .ALUOp     (aluop),
    .NextPC    (nextpc),
    .RegW      (regw),
    .MemW      (memw),
    .Branch    (branch),
    .State     (state)
  );

  always #5 clk = ~clk;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch}
  assign obs_word = {irwrite, adrsrc, alusrca, alusrcb, resultsrc, aluop, nextpc, regw, memw, branch};

  function automatic logic [11:0] exp_word(input logic [3:0] s);
    case (s)
      4'd0:    return 12'b1_0_1_10_10_0_1_0_0_0;
      4'd1:    return 12'b0_0_1_10_10_0_0_0_0_0;
      4'd2:    return 12'b0_0_0_01_00_0_0_0_0_0;
      4'd3:    return 12'b0_1_0_00_00_0_0_0_0_0;
      4'd4:    return 12'b0_0_0_00_01_0_0_1_0_0;
      4'd5:    return 12'b0_1_0_00_00_0_0_0_1_0;
      4'd6:    return 12'b0_0_0_00_00_1_0_0_0_0;
      4'd7:    return 12'b0_0_0_01_00_1_0_0_0_0;
      4'd8:    return 12'b0_0_0_00_00_0_0_1_0_0;
      4'd9:    return 12'b0_0_0_01_10_0_0_0_0_1;
      default: return 12'b0;
    endcase
  endfunction

  // Real opcode only where the FSM samples it; inverted garbage elsewhere.
  task automatic drive(input logic [3:0] cur, input logic [1:0] o, input logic [5:0] f);
    if (cur == 4'd1 || cur == 4'd2) begin
      op = o; funct = f;
    end else begin
      op = ~o; funct = ~f;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 2'b11; funct = 6'b111111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || obs_word !== 12'b1_0_1_10_10_0_1_0_0_0) begin
      errors++;
      $display("FAIL reset state=%0d word=%b expected state=0 word=%b", state, obs_word, 12'b1_0_1_10_10_0_1_0_0_0);
    end
    reset = 1'b0;
  endtask

  task automatic test_ldr();
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== seq[i] || obs_word !== exp_word(seq[i])) begin
        errors++;
        $display("FAIL ldr step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq[i], exp_word(seq[i]));
      end
      if (i < 5) begin drive(seq[i], 2'b01, 6'b000001); tick(); end
    end
  endtask

  task automatic test_str();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== seq[i] || obs_word !== exp_word(seq[i])) begin
        errors++;
        $display("FAIL str step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq[i], exp_word(seq[i]));
      end
      if (i < 4) begin drive(seq[i], 2'b01, 6'b000000); tick(); end
    end
  endtask

  task automatic test_dp();
    logic [3:0] seq_r [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    logic [3:0] seq_i [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== seq_r[i] || obs_word !== exp_word(seq_r[i])) begin
        errors++;
        $display("FAIL dp_reg step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq_r[i], exp_word(seq_r[i]));
      end
      if (i < 4) begin drive(seq_r[i], 2'b00, 6'b001000); tick(); end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== seq_i[i] || obs_word !== exp_word(seq_i[i])) begin
        errors++;
        $display("FAIL dp_imm step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq_i[i], exp_word(seq_i[i]));
      end
      if (i < 4) begin drive(seq_i[i], 2'b00, 6'b101000); tick(); end
    end
  endtask

  task automatic test_branch_unknown();
    logic [3:0] seq_b [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic [3:0] seq_u [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== seq_b[i] || obs_word !== exp_word(seq_b[i])) begin
        errors++;
        $display("FAIL branch step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq_b[i], exp_word(seq_b[i]));
      end
      if (i < 3) begin drive(seq_b[i], 2'b10, 6'b010101); tick(); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== seq_u[i] || obs_word !== exp_word(seq_u[i])) begin
        errors++;
        $display("FAIL unknown step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq_u[i], exp_word(seq_u[i]));
      end
      if (i < 3) begin drive(seq_u[i], 2'b11, 6'b100001); tick(); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq_b [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    for (int i = 0; i < 3; i++) begin drive(state, 2'b01, 6'b000001); tick(); end
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL mid_reach state=%0d expected state=3", state);
    end
    reset = 1'b1;
    op = 2'b01; funct = 6'b000001;
    tick();
    checks++;
    if (state !== 4'd0 || obs_word !== exp_word(4'd0)) begin
      errors++;
      $display("FAIL mid_reset state=%0d word=%b expected state=0 word=%b", state, obs_word, exp_word(4'd0));
    end
    reset = 1'b0;
    // Abandoned load must not write back; new branch proceeds normally.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== seq_b[i] || obs_word !== exp_word(seq_b[i]) || regw !== 1'b0 || memw !== 1'b0) begin
        errors++;
        $display("FAIL mid_after step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq_b[i], exp_word(seq_b[i]));
      end
      if (i < 3) begin drive(seq_b[i], 2'b10, 6'b000001); tick(); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (state !== seq[i] || obs_word !== exp_word(seq[i])) begin
        errors++;
        $display("FAIL b2b step %0d state=%0d word=%b expected state=%0d word=%b", i, state, obs_word, seq[i], exp_word(seq[i]));
      end
      if (i < 4) drive(seq[i], 2'b01, 6'b100000);
      else drive(seq[i], 2'b01, 6'b100001);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_str();
    test_dp();
    test_branch_unknown();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
